// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read handshake plus the
// valid/ready channel that hands fetched words to the decoder.
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  // Fetch stage side: drives the memory request and the decoder channel.
  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_rdata, mem_ack, instr_ready
  );

  // Memory / decoder side.
  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_rdata, mem_ack, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32I fetch stage: reads the word at pc_val from instruction memory,
// holds it for the decoder and steps the PC register once per accepted fetch.
//
// state | meaning
// IDLE  | sample pc_val, check alignment, latch the fetch address
// REQ   | memory read outstanding; the ack captures the instruction
// HOLD  | instruction presented to the decoder, waiting for instr_ready
// DRAIN | flushed read still outstanding; its data will be thrown away
// FAULT | misaligned PC seen; sticky until flush or reset
module instr_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [31:0]   pc_val,
  input  logic          flush,
  instr_fetch_if.master bus,
  output logic          pc_inc,
  output logic          pc_hold,
  output logic          fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] ipc_q, ipc_nxt;
  logic        aligned;

  assign aligned = (pc_val[1:0] == 2'b00);

  // State and datapath registers; reset parks a NOP in front of the decoder.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      instr_q <= instr_nxt;
      ipc_q   <= ipc_nxt;
    end
  end

  // Next-state and capture logic; flush overrides every normal transition.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    instr_nxt = instr_q;
    ipc_nxt   = ipc_q;
    if (flush) begin
      instr_nxt = NOP_INSTR;
      case (state)
        // A live bus request is never withdrawn. If the ack arrives in the
        // flush cycle (from REQ or DRAIN) that request is finished and there
        // is nothing left to drain, so waiting for another ack would hang.
        S_REQ, S_DRAIN: state_nxt = bus.mem_ack ? S_IDLE : S_DRAIN;
        default:        state_nxt = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (!aligned) begin
            state_nxt = S_FAULT;
          end else begin
            addr_nxt  = pc_val;
            state_nxt = S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            instr_nxt = bus.mem_rdata;
            ipc_nxt   = addr_q;
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          // pc_val already points at the next word here: the PC stepped on
          // the capture edge.
          if (bus.instr_ready) begin
            if (aligned) begin
              addr_nxt  = pc_val;
              state_nxt = S_REQ;
            end else begin
              state_nxt = S_FAULT;
            end
          end
        end
        S_DRAIN: begin
          if (bus.mem_ack) state_nxt = S_IDLE;
        end
        S_FAULT: state_nxt = S_FAULT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.mem_req     = (state == S_REQ) || (state == S_DRAIN);
  assign bus.mem_addr    = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = (state == S_HOLD);
  assign fetch_fault     = (state == S_FAULT);

  // The PC steps only on a response that is kept; during a flush the hold is
  // released so the PC register can take the branch target.
  assign pc_inc  = (state == S_REQ) && bus.mem_ack && !flush;
  assign pc_hold = !(pc_inc || flush);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a cycle table of directed vectors, a reset-during-
// request sequence, then randomized traffic checked against a transaction
// model (queue of kept fetch addresses, PC register and memory played here).
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D0  = 32'h0050_0093;
  localparam logic [31:0] A1  = 32'h0040_0113;
  localparam logic [31:0] A2  = 32'h0080_0193;
  localparam logic [31:0] A3  = 32'h00c0_0213;
  localparam logic [31:0] A4  = 32'h0100_0293;
  localparam logic [31:0] JNK = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] pc_val = '0;
  logic        flush = 1'b0;
  logic        pc_inc, pc_hold, fetch_fault;

  instr_fetch_if bus ();

  instr_fetch #(.NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .clr        (clr),
    .pc_val     (pc_val),
    .flush      (flush),
    .bus        (bus),
    .pc_inc     (pc_inc),
    .pc_hold    (pc_hold),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        fl;
    logic        ak;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic        ci;
    logic [31:0] e_ins;
    logic [31:0] e_ipc;
    logic        e_inc;
    logic        e_hold;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0dcd) ^ 32'h1357_9bdf;
  endfunction

  task automatic add(input logic [31:0] pc, input logic fl, input logic ak,
                     input logic [31:0] rd, input logic rdy,
                     input logic req, input logic [31:0] addr, input logic vld,
                     input logic ci, input logic [31:0] ins, input logic [31:0] ipc,
                     input logic inc, input logic hold, input logic flt);
    vec_t v;
    v.pc = pc; v.fl = fl; v.ak = ak; v.rd = rd; v.rdy = rdy;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.ci = ci;
    v.e_ins = ins; v.e_ipc = ipc; v.e_inc = inc; v.e_hold = hold; v.e_flt = flt;
    vecs.push_back(v);
  endtask

  task automatic run_random(input int cycles);
    logic [31:0] pc_m = '0;
    logic [31:0] q[$];
    logic        discarding = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_flush = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] tgt;
    logic        exp_inc, exp_hold, exp_vld;
    int          idle_run = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      pc_val = pc_m;
      flush  = ($urandom_range(0, 19) == 0);
      tgt    = $urandom_range(0, 1023) << 2;
      bus.mem_ack     = bus.mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.mem_rdata   = (bus.mem_req && bus.mem_ack) ? mem_word(bus.mem_addr) : $urandom;
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_inc  = bus.mem_req & bus.mem_ack & ~flush & ~discarding;
      exp_hold = ~(exp_inc | flush);
      exp_vld  = (q.size() != 0);
      chk("rnd_pc_inc", pc_inc, exp_inc);
      chk("rnd_pc_hold", pc_hold, exp_hold);
      chk("rnd_fault", fetch_fault, 1'b0);
      chk("rnd_valid", bus.instr_valid, exp_vld);
      if (bus.instr_valid && q.size() != 0) begin
        chk("rnd_instr_pc", bus.instr_pc, q[0]);
        chk("rnd_instr", bus.instr, mem_word(q[0]));
        if (bus.instr_ready && !flush) void'(q.pop_front());
      end
      if (prev_flush) chk("rnd_nop_after_flush", bus.instr, NOP);
      if (bus.mem_req && !prev_req) chk("rnd_req_addr", bus.mem_addr, pc_val);
      else if (bus.mem_req && prev_req) chk("rnd_addr_stable", bus.mem_addr, prev_addr);
      if (!bus.mem_req && !bus.instr_valid) begin
        if (!flush) idle_run++;
        else idle_run = 0;
        chk("rnd_idle_bound", (idle_run <= 1), 1'b1);
      end else begin
        idle_run = 0;
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (!flush && !discarding) q.push_back(bus.mem_addr);
        discarding = 1'b0;
      end else if (flush && bus.mem_req) begin
        discarding = 1'b1;
      end
      if (flush) q.delete();
      pc_m       = flush ? tgt : (pc_inc ? pc_m + 32'd4 : pc_m);
      prev_req   = bus.mem_req;
      prev_addr  = bus.mem_addr;
      prev_flush = flush;
    end
    flush = 1'b0;
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.instr_ready = 1'b0;

    //   pc     fl ak rd   rdy | req addr   vld ci ins  ipc    inc hold flt
    add(32'h00, 0, 0, 0,   0,   0, 32'h00, 0, 1, NOP, 32'h00, 0, 1, 0);
    add(32'h00, 0, 0, 0,   0,   1, 32'h00, 0, 0, 0,   0,      0, 1, 0);
    add(32'h00, 0, 0, 0,   0,   1, 32'h00, 0, 0, 0,   0,      0, 1, 0);
    add(32'h00, 0, 1, D0,  0,   1, 32'h00, 0, 0, 0,   0,      1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(32'h04, 0, 0, 0, 0,   0, 32'h00, 1, 1, D0,  32'h00, 0, 1, 0);
    add(32'h04, 0, 0, 0,   1,   0, 32'h00, 1, 1, D0,  32'h00, 0, 1, 0);
    add(32'h04, 0, 1, A1,  1,   1, 32'h04, 0, 0, 0,   0,      1, 0, 0);
    add(32'h08, 0, 0, 0,   1,   0, 32'h04, 1, 1, A1,  32'h04, 0, 1, 0);
    add(32'h08, 0, 1, A2,  1,   1, 32'h08, 0, 0, 0,   0,      1, 0, 0);
    add(32'h0c, 0, 0, 0,   1,   0, 32'h08, 1, 1, A2,  32'h08, 0, 1, 0);
    add(32'h0c, 0, 1, A3,  1,   1, 32'h0c, 0, 0, 0,   0,      1, 0, 0);
    add(32'h10, 0, 0, 0,   1,   0, 32'h0c, 1, 1, A3,  32'h0c, 0, 1, 0);
    add(32'h10, 1, 1, JNK, 1,   1, 32'h10, 0, 0, 0,   0,      0, 0, 0);
    add(32'h10, 0, 0, 0,   0,   0, 32'h10, 0, 1, NOP, 0,      0, 1, 0);
    add(32'h10, 0, 0, 0,   0,   1, 32'h10, 0, 1, NOP, 0,      0, 1, 0);
    add(32'h10, 1, 0, 0,   0,   1, 32'h10, 0, 1, NOP, 0,      0, 0, 0);
    add(32'h40, 0, 0, 0,   0,   1, 32'h10, 0, 1, NOP, 0,      0, 1, 0);
    add(32'h40, 0, 1, JNK, 0,   1, 32'h10, 0, 1, NOP, 0,      0, 1, 0);
    add(32'h40, 0, 0, 0,   0,   0, 32'h10, 0, 1, NOP, 0,      0, 1, 0);
    add(32'h40, 0, 1, A4,  0,   1, 32'h40, 0, 1, NOP, 0,      1, 0, 0);
    add(32'h46, 0, 1, JNK, 1,   0, 32'h40, 1, 1, A4,  32'h40, 0, 1, 0);
    add(32'h46, 0, 1, JNK, 0,   0, 32'h40, 0, 0, 0,   0,      0, 1, 1);
    add(32'h46, 1, 0, 0,   0,   0, 32'h40, 0, 0, 0,   0,      0, 0, 1);
    add(32'h06, 0, 0, 0,   0,   0, 32'h40, 0, 1, NOP, 0,      0, 1, 0);
    add(32'h06, 0, 0, 0,   0,   0, 32'h40, 0, 0, 0,   0,      0, 1, 1);
    add(32'h06, 0, 1, JNK, 0,   0, 32'h40, 0, 0, 0,   0,      0, 1, 1);
    add(32'h06, 1, 0, 0,   0,   0, 32'h40, 0, 0, 0,   0,      0, 0, 1);
    add(32'h08, 0, 0, 0,   0,   0, 32'h40, 0, 1, NOP, 0,      0, 1, 0);
    add(32'h08, 0, 0, 0,   0,   1, 32'h08, 0, 1, NOP, 0,      0, 1, 0);

    // Reset values, with a stray ack present to show it cannot step the PC.
    bus.mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_fault", fetch_fault, 1'b0);
    chk("rst_pc_inc", pc_inc, 1'b0);
    chk("rst_pc_hold", pc_hold, 1'b1);
    bus.mem_ack = 1'b0;
    clr = 1'b1;

    foreach (vecs[i]) begin
      pc_val          = vecs[i].pc;
      flush           = vecs[i].fl;
      bus.mem_ack     = vecs[i].ak;
      bus.mem_rdata   = vecs[i].rd;
      bus.instr_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_mem_req", i), bus.mem_req, vecs[i].e_req);
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), bus.instr_valid, vecs[i].e_vld);
      chk($sformatf("v%0d_pc_inc", i), pc_inc, vecs[i].e_inc);
      chk($sformatf("v%0d_pc_hold", i), pc_hold, vecs[i].e_hold);
      chk($sformatf("v%0d_fault", i), fetch_fault, vecs[i].e_flt);
      if (vecs[i].ci) chk($sformatf("v%0d_instr", i), bus.instr, vecs[i].e_ins);
      if (vecs[i].e_vld) chk($sformatf("v%0d_instr_pc", i), bus.instr_pc, vecs[i].e_ipc);
      @(posedge clk); #1;
    end

    // Reset while a request is outstanding drops it without waiting for a clock.
    flush = 1'b0;
    bus.mem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    chk("midrst_req_before", bus.mem_req, 1'b1);
    clr = 1'b0;
    #1;
    chk("midrst_req_after", bus.mem_req, 1'b0);
    chk("midrst_addr", bus.mem_addr, 32'h0);
    chk("midrst_hold", pc_hold, 1'b1);
    pc_val = '0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;

    run_random(4000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
